// File: rtl/axi4_pkg.sv
// axi4_pkg: constants and types shared by the AXI4 master bridge.
//   state_t      - bridge FSM states
//   BURST_INCR   - AXI incrementing burst encoding
//   RESP_OKAY    - AXI OKAY response
//   RESP_SLVERR  - AXI SLVERR response
//   ADDR_W, DATA_W, ID_W - AXI channel widths
`timescale 1ns/1ps
package axi4_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5
  } state_t;

endpackage

// File: rtl/axi4_master_bridge.sv
// axi4_master_bridge: converts a simple request / write-data / response
// interface into AXI4 master transactions, one transaction in flight.
// Ports:
//   clock, reset_n            - clock, asynchronous active-low reset
//   req_*                     - transaction request (write flag, addr, size, len)
//   wdat_*                    - write data stream from the client
//   rsp_*                     - read data beats / write completion to the client
//   io_master_aw/w/b/ar/r*    - AXI4 master channels
// The address channel fields come from registers captured at request
// acceptance; data beats and responses are passed through combinationally
// while the owning state is active, so data beats add no latency.
`timescale 1ns/1ps
module axi4_master_bridge
  import axi4_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_len,
  // write-data channel
  input  logic        wdat_valid,
  output logic        wdat_ready,
  input  logic [63:0] wdat_data,
  input  logic [7:0]  wdat_strb,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  // AXI write address
  input  logic        io_master_awready,
  output logic        io_master_awvalid,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  // AXI write data
  input  logic        io_master_wready,
  output logic        io_master_wvalid,
  output logic [63:0] io_master_wdata,
  output logic [7:0]  io_master_wstrb,
  output logic        io_master_wlast,
  // AXI write response
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  output logic        io_master_bready,
  // AXI read address
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  // AXI read data
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [63:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic        io_master_rready
);

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic        accept;
  logic        beat;
  logic        at_last;

  // IDs of returning beats are not used: only one transaction is ever open.
  logic unused_ids;
  assign unused_ids = ^{io_master_bid, io_master_rid, io_master_bresp[0],
                        io_master_rresp[0]};

  assign accept  = req_valid && req_ready;
  assign at_last = (cnt_q == len_q);

  // Address channels: fields straight from the captured request.
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = len_q;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = BURST_INCR;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = BURST_INCR;

  // Write data fields pass through; only wvalid is gated by the state, so
  // early client data sits on the bus but is not offered to the slave.
  assign io_master_wdata = wdat_data;
  assign io_master_wstrb = wdat_strb;
  assign io_master_wlast = at_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= req_addr;
        size_q <= req_size;
        len_q  <= req_len;
        cnt_q  <= '0;
      end else if (beat) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    req_ready         = 1'b0;
    wdat_ready        = 1'b0;
    rsp_valid         = 1'b0;
    rsp_data          = '0;
    rsp_last          = 1'b0;
    rsp_err           = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    beat              = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_write ? WADDR : RADDR;
      end
      RADDR: begin
        io_master_arvalid = 1'b1;
        if (io_master_arready) state_nxt = RDATA;
      end
      RDATA: begin
        io_master_rready = rsp_ready;
        rsp_valid        = io_master_rvalid;
        rsp_data         = io_master_rdata;
        rsp_last         = io_master_rlast;
        // A slave error, or rlast not landing on the beat we expect.
        rsp_err          = io_master_rresp[1] || (io_master_rlast != at_last);
        beat             = io_master_rvalid && rsp_ready;
        if (beat && io_master_rlast) state_nxt = IDLE;
      end
      WADDR: begin
        io_master_awvalid = 1'b1;
        if (io_master_awready) state_nxt = WDATA;
      end
      WDATA: begin
        io_master_wvalid = wdat_valid;
        wdat_ready       = io_master_wready;
        beat             = wdat_valid && io_master_wready;
        if (beat && at_last) state_nxt = WRESP;
      end
      WRESP: begin
        rsp_valid        = io_master_bvalid;
        io_master_bready = rsp_ready;
        rsp_last         = 1'b1;
        rsp_err          = io_master_bresp[1];
        if (io_master_bvalid && rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/axi4_master_bridge.md
AXI4_MASTER_BRIDGE -- requirements
Module: axi4_master_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0, the constant driven on io_master_awid and io_master_arid.
REQ-002 SHALL have clock  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have the request channel: req_valid in 1, req_ready out 1, req_write in 1, req_addr in 32, req_size in 3, req_len in 8 (beats minus 1).
REQ-005 SHALL have the write-data channel: wdat_valid in 1, wdat_ready out 1, wdat_data in 64, wdat_strb in 8.
REQ-006 SHALL have the response channel: rsp_valid out 1, rsp_ready in 1, rsp_data out 64, rsp_last out 1, rsp_err out 1.
REQ-007 SHALL have io_master_aw*: awready in; awvalid out 1, awaddr 32, awid 4, awlen 8, awsize 3, awburst 2.
REQ-008 SHALL have io_master_w*: wready in; wvalid out 1, wdata 64, wstrb 8, wlast 1.
REQ-009 SHALL have io_master_b*: bvalid in 1, bresp in 2, bid in 4; bready out 1.
REQ-010 SHALL have io_master_ar*: arready in; arvalid out 1, araddr 32, arid 4, arlen 8, arsize 3, arburst 2.
REQ-011 SHALL have io_master_r*: rvalid in 1, rresp in 2, rdata in 64, rlast in 1, rid in 4; rready out 1.

Function
REQ-012 SHALL implement the FSM states IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, with one transaction outstanding at most.
REQ-013 SHALL drive req_ready=1 only in IDLE; on req_valid&req_ready it SHALL register addr/size/len, clear the beat counter, and go to WADDR if req_write, else RADDR.
REQ-014 SHALL drive arvalid/awvalid from the cycle after acceptance until the handshake; address, len and size SHALL stay stable while valid; burst SHALL be 2'b01 (INCR).
REQ-015 RADDR->RDATA and WADDR->WDATA SHALL occur on the respective ready&valid.
REQ-016 In RDATA: rready=rsp_ready, rsp_valid=rvalid, rsp_data=rdata, rsp_last=rlast, all combinational; rsp_err=rresp[1], or rlast disagreeing with (counter==len).
REQ-017 RDATA->IDLE SHALL occur on rvalid&rready&rlast; the counter SHALL increment per beat, 8-bit, with no wrap check beyond len.
REQ-018 In WDATA: wvalid=wdat_valid, wdat_ready=wready, wdata/wstrb passed through, wlast=(counter==len); the last beat handshake SHALL go to WRESP.
REQ-019 In WRESP: rsp_valid=bvalid, bready=rsp_ready, rsp_last=1, rsp_data=0, rsp_err=bresp[1]; the handshake SHALL go to IDLE.
REQ-020 Outside their owning state, wdat_ready, rready, bready and rsp_valid SHALL be 0; wdat_valid asserted early SHALL be held off, not dropped.
REQ-021 bid/rid SHALL be ignored; 4 KB crossing SHALL NOT be checked.
REQ-022 Latency: request accept at cycle N -> ar/awvalid high at N+1; zero added latency on data beats.

Reset
REQ-023 reset_n low SHALL force IDLE, counter 0, and all registered outputs 0 immediately, including mid-burst; arvalid, awvalid, wvalid, rready, bready, rsp_valid=0 and req_ready=1 after release.

Structure
REQ-024 The shared package axi4_pkg SHALL hold the FSM state enum, BURST_INCR=2'b01, RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and the width constants ADDR_W=32, DATA_W=64, ID_W=4.
REQ-025 SHALL be a single module; no sub-module is warranted.

Verification
REQ-026 Read with len=0, addr 0x8000_0000, size 3 -> arvalid at N+1 with arlen 0; one rsp beat, rsp_last=1, rsp_err=0; back to IDLE.
REQ-027 Read with len=3, slave inserts rvalid bubbles and rsp_ready stalls -> 4 beats in order, data unchanged, rsp_last only on beat 4.
REQ-028 Write with len=1, wdat_valid raised before awready -> no W beat before the AW handshake; wlast on beat 2; bresp=2'b10 -> rsp_err=1.
REQ-029 Read with len=3 where the slave asserts rlast on beat 2 -> rsp_err=1 on that beat; FSM to IDLE.
REQ-030 reset_n pulsed low during WDATA beat 1 -> all valids drop asynchronously; after release req_ready=1 and a new read completes normally.
